// File: rtl/uart_sector_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_sector_cmd_rx
// Purpose  : UART 8N1 receiver plus framed sector-read command decoder.
//            Frame: SYNC_BYTE, S0..S3 (little-endian sector), CHK = S0^S1^S2^S3.
//            The validated sector is offered through a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sector_cmd_rx #(
    parameter int          UART_CLK_DIV   = 434,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        rx_byte_valid,
    output logic [7:0]  rx_byte,
    output logic        cmd_valid,
    output logic [31:0] cmd_sector,
    input  logic        cmd_ready,
    output logic        err_frame,
    output logic        err_chksum,
    output logic        err_overrun
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int BIT_P = 2 * UART_CLK_DIV;
    localparam int CNT_W = (BIT_P > 2) ? $clog2(BIT_P) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(UART_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_P - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizer and edge history (idle-high line, so reset to 1)
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Bit engine
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Mid-bit sampling state machine; start is qualified at its half-bit point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state      <= RX_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= 3'd0;
            shift_reg     <= 8'h00;
            rx_byte       <= 8'h00;
            rx_byte_valid <= 1'b0;
            err_frame     <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            err_frame     <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        bit_cnt  <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (bit_cnt == '0) begin
                        if (rx_sync) begin
                            // Line went back high before mid-start: glitch.
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= BIT_LOAD;
                            bit_idx  <= 3'd0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == '0) begin
                        shift_reg[bit_idx] <= rx_sync;
                        bit_cnt            <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == '0) begin
                        if (rx_sync) begin
                            rx_byte       <= shift_reg;
                            rx_byte_valid <= 1'b1;
                            rx_state      <= RX_IDLE;
                        end else begin
                            err_frame <= 1'b1;
                            rx_state  <= RX_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                RX_BREAK: begin
                    // Hold off until the line is released so a long low
                    // level is not mistaken for a fresh start bit.
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        PS_WAIT_SYNC = 3'd0,
        PS_B0        = 3'd1,
        PS_B1        = 3'd2,
        PS_B2        = 3'd3,
        PS_B3        = 3'd4,
        PS_CHK       = 3'd5
    } ps_state_t;

    ps_state_t        ps_state;
    logic [31:0]      sector_acc;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       chk_calc;
    logic             chk_match;
    logic             timeout_hit;

    // Checksum of the collected sector bytes and the inter-byte timeout flag.
    always_comb begin
        chk_calc    = sector_acc[7:0] ^ sector_acc[15:8] ^
                      sector_acc[23:16] ^ sector_acc[31:24];
        chk_match   = (rx_byte == chk_calc);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LIMIT);
    end

    // Byte-level parser, timeout counter and command handshake register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_state    <= PS_WAIT_SYNC;
            sector_acc  <= 32'h0;
            to_cnt      <= '0;
            cmd_valid   <= 1'b0;
            cmd_sector  <= 32'h0;
            err_chksum  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_chksum  <= 1'b0;
            err_overrun <= 1'b0;

            // Consumer takes the pending command; a load below may override.
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            // Idle-gap counter only runs while a frame is in progress.
            if ((ps_state == PS_WAIT_SYNC) || rx_byte_valid) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LIMIT) begin
                to_cnt <= to_cnt + TO_ONE;
            end

            if (err_frame) begin
                ps_state <= PS_WAIT_SYNC;
            end else if (rx_byte_valid) begin
                case (ps_state)
                    PS_WAIT_SYNC: begin
                        if (rx_byte == SYNC_BYTE) begin
                            ps_state <= PS_B0;
                        end
                    end
                    PS_B0: begin
                        sector_acc[7:0] <= rx_byte;
                        ps_state        <= PS_B1;
                    end
                    PS_B1: begin
                        sector_acc[15:8] <= rx_byte;
                        ps_state         <= PS_B2;
                    end
                    PS_B2: begin
                        sector_acc[23:16] <= rx_byte;
                        ps_state          <= PS_B3;
                    end
                    PS_B3: begin
                        sector_acc[31:24] <= rx_byte;
                        ps_state          <= PS_CHK;
                    end
                    PS_CHK: begin
                        if (chk_match) begin
                            if (!cmd_valid || cmd_ready) begin
                                cmd_sector <= sector_acc;
                                cmd_valid  <= 1'b1;
                            end else begin
                                err_overrun <= 1'b1;
                            end
                        end else begin
                            err_chksum <= 1'b1;
                        end
                        ps_state <= PS_WAIT_SYNC;
                    end
                    default: begin
                        ps_state <= PS_WAIT_SYNC;
                    end
                endcase
            end else if (timeout_hit && (ps_state != PS_WAIT_SYNC)) begin
                ps_state <= PS_WAIT_SYNC;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_sector_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sector_cmd_rx
// Purpose  : Directed bench for uart_sector_cmd_rx with byte and command
//            scoreboards fed by the stimulus tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_sector_cmd_rx;

    localparam int DIV   = 16;
    localparam int BIT_P = 2 * DIV;
    localparam int TO    = 5000;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        cmd_valid;
    logic [31:0] cmd_sector;
    logic        cmd_ready;
    logic        err_frame;
    logic        err_chksum;
    logic        err_overrun;

    uart_sector_cmd_rx #(
        .UART_CLK_DIV   (DIV),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .cmd_valid     (cmd_valid),
        .cmd_sector    (cmd_sector),
        .cmd_ready     (cmd_ready),
        .err_frame     (err_frame),
        .err_chksum    (err_chksum),
        .err_overrun   (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_cmds[$];

    int n_rbv  = 0;
    int n_good = 0;
    int n_frm  = 0;
    int n_chk  = 0;
    int n_ovr  = 0;
    logic cv_prev  = 1'b0;
    logic rbv_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops and pulse counting, sampled on negedge.
    always @(negedge clk) begin
        if (rx_byte_valid) begin
            n_rbv++;
            total++;
            assert (exp_bytes.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_rx_byte observed=%0h expected=none", rx_byte);
            end
            if (exp_bytes.size() > 0) check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_bytes.pop_front()});
        end
        if (cmd_valid && !cv_prev) begin
            total++;
            assert (exp_cmds.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_cmd observed=%0h expected=none", cmd_sector);
            end
            if (exp_cmds.size() > 0) check("cmd_sector", cmd_sector, exp_cmds.pop_front());
            check("cmd_latency", {31'h0, rbv_prev}, 32'h1);
        end
        n_frm += int'(err_frame);
        n_chk += int'(err_chksum);
        n_ovr += int'(err_overrun);
        cv_prev  = cmd_valid;
        rbv_prev = rx_byte_valid;
    end

    task automatic send_byte(input logic [7:0] b, input bit good_stop, input int bclk);
        if (good_stop) begin
            exp_bytes.push_back(b);
            n_good++;
        end
        uart_rx = 1'b0;
        repeat (bclk) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (bclk) @(posedge clk);
        end
        uart_rx = good_stop;
        repeat (bclk) @(posedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] sec, input logic [7:0] chk_flip);
        logic [7:0] chk;
        chk = sec[7:0] ^ sec[15:8] ^ sec[23:16] ^ sec[31:24] ^ chk_flip;
        send_byte(8'hA5, 1'b1, BIT_P);
        send_byte(sec[7:0], 1'b1, BIT_P);
        send_byte(sec[15:8], 1'b1, BIT_P);
        send_byte(sec[23:16], 1'b1, BIT_P);
        send_byte(sec[31:24], 1'b1, BIT_P);
        send_byte(chk, 1'b1, BIT_P);
        repeat (BIT_P) @(posedge clk);
    endtask

    task automatic release_cmd(input string tag);
        @(negedge clk);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        check(tag, {31'h0, cmd_valid}, 32'h0);
        cmd_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rbv"},  {31'h0, rx_byte_valid}, 32'h0);
        check({tag, "_byte"}, {24'h0, rx_byte}, 32'h0);
        check({tag, "_cv"},   {31'h0, cmd_valid}, 32'h0);
        check({tag, "_sec"},  cmd_sector, 32'h0);
        check({tag, "_efr"},  {31'h0, err_frame}, 32'h0);
        check({tag, "_ech"},  {31'h0, err_chksum}, 32'h0);
        check({tag, "_eov"},  {31'h0, err_overrun}, 32'h0);
    endtask

    // Run-time bound so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        cmd_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Single byte
        send_byte(8'h55, 1'b1, BIT_P);
        repeat (BIT_P) @(posedge clk);
        check("single_count", n_rbv, n_good);
        check("single_rx_byte", {24'h0, rx_byte}, 32'h55);

        // Good frame, held until cmd_ready
        exp_cmds.push_back(32'h12345678);
        send_frame(32'h12345678, 8'h00);
        check("good_cv", {31'h0, cmd_valid}, 32'h1);
        check("good_sec", cmd_sector, 32'h12345678);
        release_cmd("good_release");

        // Bad checksum then a good frame
        send_frame(32'h12345678, 8'h01);
        check("badchk_count", n_chk, 1);
        check("badchk_cv", {31'h0, cmd_valid}, 32'h0);
        exp_cmds.push_back(32'hDEADBEEF);
        send_frame(32'hDEADBEEF, 8'h00);
        check("after_bad_sec", cmd_sector, 32'hDEADBEEF);
        release_cmd("after_bad_release");

        // Framing error mid-frame, then a clean frame must be accepted
        send_byte(8'hA5, 1'b1, BIT_P);
        send_byte(8'h00, 1'b0, BIT_P);
        repeat (2 * BIT_P) @(posedge clk);
        check("frame_err_count", n_frm, 1);
        exp_cmds.push_back(32'h00000003);
        send_frame(32'h00000003, 8'h00);
        check("frame_err_resync", cmd_sector, 32'h3);
        check("frame_err_chk", n_chk, 1);
        release_cmd("frame_err_release");

        // Short low glitch on an idle line
        uart_rx = 1'b0;
        repeat (DIV / 2 - 1) @(posedge clk);
        uart_rx = 1'b1;
        repeat (12 * BIT_P) @(posedge clk);
        check("glitch_count", n_rbv, n_good);

        // Overrun: second frame while the first is still pending
        exp_cmds.push_back(32'h1);
        send_frame(32'h1, 8'h00);
        send_frame(32'h2, 8'h00);
        check("overrun_count", n_ovr, 1);
        check("overrun_sec", cmd_sector, 32'h1);
        check("overrun_cv", {31'h0, cmd_valid}, 32'h1);
        release_cmd("overrun_release");

        // Inter-byte timeout returns the parser to WAIT_SYNC
        send_byte(8'hA5, 1'b1, BIT_P);
        send_byte(8'h01, 1'b1, BIT_P);
        repeat (6000) @(posedge clk);
        exp_cmds.push_back(32'h7);
        send_frame(32'h7, 8'h00);
        check("timeout_sec", cmd_sector, 32'h7);
        check("timeout_chk", n_chk, 1);
        release_cmd("timeout_release");

        // Baud mismatch, back-to-back bytes at roughly +3% and -3%
        send_byte(8'h3C, 1'b1, BIT_P + 1);
        send_byte(8'hC3, 1'b1, BIT_P - 1);
        repeat (BIT_P) @(posedge clk);
        check("baud_count", n_rbv, n_good);

        // Reset in the middle of a byte with a command pending
        exp_cmds.push_back(32'h0000AA55);
        send_frame(32'h0000AA55, 8'h00);
        check("prereset_cv", {31'h0, cmd_valid}, 32'h1);
        uart_rx = 1'b0;
        repeat (BIT_P) @(posedge clk);
        uart_rx = 1'b1;
        repeat (BIT_P) @(posedge clk);
        uart_rx = 1'b0;
        repeat (BIT_P) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midbyte_reset");
        repeat (5) @(posedge clk);
        uart_rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BIT_P) @(posedge clk);
        check("postreset_count", n_rbv, n_good);
        check("postreset_cv", {31'h0, cmd_valid}, 32'h0);
        check("final_frm", n_frm, 1);
        check("final_ovr", n_ovr, 1);
        check("final_chk", n_chk, 1);
        check("cmd_queue_left", exp_cmds.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
